laser_sched: RTL and testbench

- Frame scheduler in front of the LASER two-circle coverage engine.
- Accepts 40-point frames over a valid/ready stream and double-buffers them in two banks.
- Holds the engine parked in reset until a full frame and result space are available, then streams the frame into the engine on consecutive cycles.
- Captures C1/C2 on DONE into a 2-entry result FIFO; a watchdog aborts runs that never finish.

---
 rtl/laser_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_laser_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_sched.sv
// ---------------------------------------------------------------------------
// laser_sched
//   Frame scheduler in front of the LASER two-circle coverage engine.
//   40-point frames arrive over a valid/ready stream and are double-buffered
//   in two banks. The engine is kept in reset until a full frame is waiting
//   and there is room for its result. The frame is then streamed to the
//   engine one point per cycle. Results are captured on ENG_DONE into a
//   2-entry FIFO. A watchdog aborts runs that never signal DONE and queues
//   an all-zero result flagged as a timeout.
//
// Optional build macro:
//   LASER_SCHED_PERF_EN - adds a 16-bit saturating run-length counter per
//                         result, presented on OUT_CYCLES. When the macro is
//                         undefined, OUT_CYCLES is tied to 0.
//
// Ports:
//   CLK, RST                  clock (rising edge), async active-low reset
//   IN_VALID/IN_READY         point input handshake
//   IN_X, IN_Y                point coordinates
//   ENG_RST                   registered synchronous reset to the engine
//   ENG_X, ENG_Y              registered point stream to the engine
//   ENG_DONE                  engine done pulse
//   ENG_C1X..ENG_C2Y          engine result coordinates
//   OUT_VALID/OUT_READY       result FIFO handshake
//   OUT_C1X..OUT_C2Y          head result coordinates
//   OUT_TIMEOUT               head result came from a watchdog abort
//   BUSY                      scheduler is not parked
//   OUT_CYCLES                run length of the head result (perf build only)
// ---------------------------------------------------------------------------
module laser_sched #(
  parameter int          N_POINTS       = 40,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [3:0]  IN_X,
  input  logic [3:0]  IN_Y,
  output logic        ENG_RST,
  output logic [3:0]  ENG_X,
  output logic [3:0]  ENG_Y,
  input  logic        ENG_DONE,
  input  logic [3:0]  ENG_C1X,
  input  logic [3:0]  ENG_C1Y,
  input  logic [3:0]  ENG_C2X,
  input  logic [3:0]  ENG_C2Y,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [3:0]  OUT_C1X,
  output logic [3:0]  OUT_C1Y,
  output logic [3:0]  OUT_C2X,
  output logic [3:0]  OUT_C2Y,
  output logic        OUT_TIMEOUT,
  output logic        BUSY,
  output logic [15:0] OUT_CYCLES
);

  localparam int            IW       = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);

  typedef enum logic [1:0] {S_PARK, S_STREAM, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [7:0]    bank_q [2][N_POINTS];
  logic [1:0]    full_q, full_d;
  logic          wrBank_q, wrBank_d, rdBank_q, rdBank_d;
  logic [IW-1:0] wrIdx_q, wrIdx_d, rdIdx_q, rdIdx_d;
  logic [15:0]   wd_q, wd_d;
  logic          engRst_q, engRst_d;
  logic [3:0]    engX_q, engX_d, engY_q, engY_d;
  logic [16:0]   fifo_q [2];
  logic          fifoWr_q, fifoRd_q;
  logic [1:0]    count_q;

  logic          accept, wrLast, relBank, capture, abort, push, pop;
  logic          launchOk, launch;
  logic [1:0]    occ;
  logic [16:0]   entry, head;

  assign IN_READY = RST & ~full_q[wrBank_q];
  assign accept   = IN_VALID & IN_READY;
  assign wrLast   = (wrIdx_q == LAST_IDX);
  assign relBank  = (state_q == S_STREAM) && (rdIdx_q == LAST_IDX);
  assign capture  = (state_q == S_WAIT) && ENG_DONE;
  assign abort    = (state_q == S_WAIT) && !ENG_DONE && (wd_q == TIMEOUT_CYCLES);
  assign push     = capture | abort;
  assign pop      = OUT_READY && (count_q != 2'd0);

  // Results that will need FIFO space: queued entries plus the run in flight.
  // A run that completes this cycle is counted once, as the in-flight run
  // turning into its captured entry, so launching only when this stays <= 1
  // guarantees the next DONE always finds a free slot.
  assign occ      = count_q + {1'b0, (state_q != S_PARK)};
  assign launchOk = full_q[rdBank_q] && (occ <= 2'd1);
  assign launch   = (state_d == S_STREAM) && (state_q != S_STREAM);

  assign entry = capture ? {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y, 1'b0}
                         : {16'h0000, 1'b1};

  // Bank bookkeeping: a fill on one bank and a release of the other can
  // land on the same cycle, so each touches only its own full bit.
  always_comb begin
    full_d   = full_q;
    wrBank_d = wrBank_q;
    wrIdx_d  = wrIdx_q;
    rdBank_d = rdBank_q;
    if (accept) begin
      if (wrLast) begin
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = ~wrBank_q;
        wrIdx_d          = '0;
      end else begin
        wrIdx_d = wrIdx_q + 1'b1;
      end
    end
    if (relBank) begin
      full_d[rdBank_q] = 1'b0;
      rdBank_d         = ~rdBank_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_PARK;
    else      state_q <= state_d;
  end

  // FSM next state. From WAIT a completed run can chain straight into the
  // next frame without parking the engine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PARK:   if (launchOk) state_d = S_STREAM;
      S_STREAM: if (relBank)  state_d = S_WAIT;
      S_WAIT: begin
        if (capture)    state_d = launchOk ? S_STREAM : S_PARK;
        else if (abort) state_d = S_PARK;
      end
      default:  state_d = S_PARK;
    endcase
  end

  // FSM outputs. ENG_X/Y carry the point the engine consumes next cycle;
  // the bank is released as soon as its last point sits in the output
  // register, since nothing reads the bank after that.
  always_comb begin
    engRst_d = engRst_q;
    engX_d   = engX_q;
    engY_d   = engY_q;
    rdIdx_d  = rdIdx_q;
    wd_d     = wd_q;
    case (state_q)
      S_PARK: begin
        engRst_d = 1'b1;
        engX_d   = 4'd0;
        engY_d   = 4'd0;
      end
      S_STREAM: begin
        engRst_d         = 1'b0;
        {engX_d, engY_d} = bank_q[rdBank_q][rdIdx_q];
        rdIdx_d          = relBank ? '0 : rdIdx_q + 1'b1;
        if (relBank) wd_d = 16'd0;
      end
      S_WAIT: begin
        engRst_d = push;
        engX_d   = 4'd0;
        engY_d   = 4'd0;
        wd_d     = wd_q + 16'd1;
      end
      default: begin
        engRst_d = 1'b1;
        engX_d   = 4'd0;
        engY_d   = 4'd0;
      end
    endcase
    if (launch) begin
      engRst_d         = 1'b0;
      {engX_d, engY_d} = bank_q[rdBank_q][0];
      rdIdx_d          = IW'(1);
    end
  end

  // Control and engine-facing registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full_q   <= 2'b00;
      wrBank_q <= 1'b0;
      rdBank_q <= 1'b0;
      wrIdx_q  <= '0;
      rdIdx_q  <= '0;
      wd_q     <= 16'd0;
      engRst_q <= 1'b1;
      engX_q   <= 4'd0;
      engY_q   <= 4'd0;
    end else begin
      full_q   <= full_d;
      wrBank_q <= wrBank_d;
      rdBank_q <= rdBank_d;
      wrIdx_q  <= wrIdx_d;
      rdIdx_q  <= rdIdx_d;
      wd_q     <= wd_d;
      engRst_q <= engRst_d;
      engX_q   <= engX_d;
      engY_q   <= engY_d;
    end
  end

  // Point storage needs no reset: the full flags decide what is valid.
  always_ff @(posedge CLK) begin
    if (accept) bank_q[wrBank_q][wrIdx_q] <= {IN_X, IN_Y};
  end

  // Result FIFO. The launch rule means a push never meets a full FIFO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fifoWr_q  <= 1'b0;
      fifoRd_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[fifoWr_q] <= entry;
        fifoWr_q         <= ~fifoWr_q;
      end
      if (pop) fifoRd_q <= ~fifoRd_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign OUT_VALID = (count_q != 2'd0);
  assign head      = fifo_q[fifoRd_q];
  assign {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y, OUT_TIMEOUT} = OUT_VALID ? head : 17'd0;
  assign BUSY      = (state_q != S_PARK);
  assign ENG_RST   = engRst_q;
  assign ENG_X     = engX_q;
  assign ENG_Y     = engY_q;

`ifdef LASER_SCHED_PERF_EN
  logic [15:0] runCnt_q, runNext;
  logic [15:0] cyc_q [2];

  // Counts from the cycle point 0 is presented up to and including the
  // DONE or abort cycle, saturating at all-ones.
  assign runNext = (&runCnt_q) ? runCnt_q : runCnt_q + 16'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      runCnt_q <= 16'd0;
      cyc_q[0] <= 16'd0;
      cyc_q[1] <= 16'd0;
    end else begin
      if (launch)                 runCnt_q <= 16'd0;
      else if (state_q != S_PARK) runCnt_q <= runNext;
      if (push) cyc_q[fifoWr_q] <= runNext;
    end
  end

  assign OUT_CYCLES = OUT_VALID ? cyc_q[fifoRd_q] : 16'd0;
`else
  assign OUT_CYCLES = 16'd0;
`endif

endmodule

// File: tb/tb_laser_sched.sv
// ---------------------------------------------------------------------------
// tb_laser_sched
//   Directed bench for laser_sched. A table of single-frame runs (normal
//   completions and one watchdog abort) is applied in a loop, followed by
//   hand-written sequences for back-to-back chaining, FIFO back-pressure
//   and an asynchronous reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_laser_sched;

  localparam int          NP  = 40;
  localparam logic [15:0] TMO = 16'd1000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [3:0]  IN_X, IN_Y;
  logic        ENG_RST;
  logic [3:0]  ENG_X, ENG_Y;
  logic        ENG_DONE;
  logic [3:0]  ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [3:0]  OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y;
  logic        OUT_TIMEOUT;
  logic        BUSY;
  logic [15:0] OUT_CYCLES;

  laser_sched #(.N_POINTS(NP), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_X(IN_X), .IN_Y(IN_Y),
    .ENG_RST(ENG_RST), .ENG_X(ENG_X), .ENG_Y(ENG_Y), .ENG_DONE(ENG_DONE),
    .ENG_C1X(ENG_C1X), .ENG_C1Y(ENG_C1Y), .ENG_C2X(ENG_C2X), .ENG_C2Y(ENG_C2Y),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_C1X(OUT_C1X), .OUT_C1Y(OUT_C1Y), .OUT_C2X(OUT_C2X), .OUT_C2Y(OUT_C2Y),
    .OUT_TIMEOUT(OUT_TIMEOUT), .BUSY(BUSY), .OUT_CYCLES(OUT_CYCLES)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          seed;
    logic [3:0]  c1x, c1y, c2x, c2y;
    int          doneDelay;
    logic [15:0] expCoords;
    logic        expTo;
  } vec_t;

  vec_t vecs[5];

  // Frame contents: seed 0 gives X = k%16, Y = k/16.
  function automatic logic [3:0] ptX(input int s, input int k);
    return 4'((k + s) % 16);
  endfunction

  function automatic logic [3:0] ptY(input int s, input int k);
    return 4'(((k / 16) + 3 * s) % 16);
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] outCoords();
    return {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y};
  endfunction

  // Push one frame with IN_VALID held high; a frame that has to wait for a
  // free bank is reported as a stall.
  task automatic applyStimulus(input int seed);
    int stalls = 0;
    for (int k = 0; k < NP; k++) begin
      IN_VALID = 1'b1;
      IN_X     = ptX(seed, k);
      IN_Y     = ptY(seed, k);
      while (!IN_READY && stalls < 3000) begin
        tick();
        stalls++;
      end
      if (!IN_READY) begin
        checkOutput("in_ready_timeout", {31'd0, IN_READY}, 32'd1);
        break;
      end
      tick();
    end
    IN_VALID = 1'b0;
    checkOutput("in_ready_cont", stalls, 0);
  endtask

  // Expects point 0 of the frame to be on ENG_X/Y now, then walks all points.
  task automatic streamFrom(input int seed);
    int errs = 0;
    for (int k = 0; k < NP; k++) begin
      if ({ENG_RST, ENG_X, ENG_Y} !== {1'b0, ptX(seed, k), ptY(seed, k)}) errs++;
      tick();
    end
    checkOutput("stream", errs, 0);
  endtask

  task automatic engineDone(input logic [15:0] res);
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = res;
    ENG_DONE = 1'b1;
    tick();
    ENG_DONE = 1'b0;
  endtask

  task automatic popOne();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  // One complete frame: load, launch latency, stream, DONE or abort, pop.
  task automatic runRec(input vec_t v);
    int n = 0;
    applyStimulus(v.seed);
    checkOutput("launch_wait", {31'd0, ENG_RST}, 32'd1);
    tick();
    checkOutput("launch", {31'd0, ENG_RST}, 32'd0);
    streamFrom(v.seed);
    checkOutput("eng_idle", {24'd0, ENG_X, ENG_Y}, 32'd0);
    if (v.doneDelay >= 0) begin
      repeat (v.doneDelay) tick();
      checkOutput("no_early_out", {31'd0, OUT_VALID}, 32'd0);
      engineDone({v.c1x, v.c1y, v.c2x, v.c2y});
    end else begin
      {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = {v.c1x, v.c1y, v.c2x, v.c2y};
      while (!OUT_VALID && n < int'(TMO) + 50) begin
        tick();
        n++;
      end
      checkOutput("abort_time", {31'd0, (n >= int'(TMO) - 2) && (n <= int'(TMO) + 2)}, 32'd1);
    end
    checkOutput("out_valid", {31'd0, OUT_VALID}, 32'd1);
    checkOutput("out_coords", {16'd0, outCoords()}, {16'd0, v.expCoords});
    checkOutput("out_timeout", {31'd0, OUT_TIMEOUT}, {31'd0, v.expTo});
    checkOutput("eng_rst_after", {31'd0, ENG_RST}, 32'd1);
    checkOutput("busy_after", {31'd0, BUSY}, 32'd0);
    popOne();
    checkOutput("pop_empty", {31'd0, OUT_VALID}, 32'd0);
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish, want finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    vecs[0] = '{seed: 0,  c1x: 4'd3,  c1y: 4'd4,  c2x: 4'd11, c2y: 4'd9, doneDelay: 500, expCoords: 16'h34B9, expTo: 1'b0};
    vecs[1] = '{seed: 5,  c1x: 4'd15, c1y: 4'd0,  c2x: 4'd7,  c2y: 4'd12, doneDelay: 1,  expCoords: 16'hF07C, expTo: 1'b0};
    vecs[2] = '{seed: 9,  c1x: 4'd9,  c1y: 4'd9,  c2x: 4'd9,  c2y: 4'd9, doneDelay: -1,  expCoords: 16'h0000, expTo: 1'b1};
    vecs[3] = '{seed: 12, c1x: 4'd0,  c1y: 4'd15, c2x: 4'd15, c2y: 4'd0, doneDelay: 0,   expCoords: 16'h0FF0, expTo: 1'b0};
    vecs[4] = '{seed: 42, c1x: 4'd6,  c1y: 4'd1,  c2x: 4'd13, c2y: 4'd2, doneDelay: 20,  expCoords: 16'h61D2, expTo: 1'b0};

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_X      = 4'd0;
    IN_Y      = 4'd0;
    ENG_DONE  = 1'b0;
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = 16'h0000;
    OUT_READY = 1'b0;

    // Reset values, taken before any clock edge.
    #2 RST = 1'b0;
    #2;
    checkOutput("rst_eng_rst", {31'd0, ENG_RST}, 32'd1);
    checkOutput("rst_eng_xy", {24'd0, ENG_X, ENG_Y}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, IN_READY}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    checkOutput("rst_out_data", {15'd0, outCoords(), OUT_TIMEOUT}, 32'd0);
    checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_cycles", {16'd0, OUT_CYCLES}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_in_ready_held", {31'd0, IN_READY}, 32'd0);
    #2 RST = 1'b1;
    tick();
    checkOutput("ready_after_reset", {31'd0, IN_READY}, 32'd1);

    // DONE while parked must not produce a result.
    engineDone(16'hFFFF);
    checkOutput("stray_done", {31'd0, OUT_VALID}, 32'd0);
    checkOutput("stray_busy", {31'd0, BUSY}, 32'd0);

    for (int i = 0; i < 4; i++) runRec(vecs[i]);

    // Three frames with results drained immediately: frames 2 and 3 chain
    // straight after DONE without an engine reset pulse.
    OUT_READY = 1'b1;
    applyStimulus(20);
    applyStimulus(21);
    applyStimulus(22);
    checkOutput("a_both_full", {31'd0, IN_READY}, 32'd0);
    checkOutput("a_busy", {31'd0, BUSY}, 32'd1);
    engineDone(16'h1234);
    checkOutput("a_b2b_rst", {31'd0, ENG_RST}, 32'd0);
    checkOutput("a_head1", {16'd0, outCoords()}, 32'h1234);
    streamFrom(21);
    engineDone(16'h5678);
    checkOutput("a_b2b_rst2", {31'd0, ENG_RST}, 32'd0);
    checkOutput("a_head2", {16'd0, outCoords()}, 32'h5678);
    streamFrom(22);
    engineDone(16'h9ABC);
    checkOutput("a_park_end", {31'd0, ENG_RST}, 32'd1);
    checkOutput("a_head3", {16'd0, outCoords()}, 32'h9ABC);
    tick();
    checkOutput("a_drained", {31'd0, OUT_VALID}, 32'd0);
    OUT_READY = 1'b0;

    // Results never drained: two queue up, the third frame parks until a pop.
    applyStimulus(30);
    applyStimulus(31);
    applyStimulus(32);
    engineDone(16'h2345);
    checkOutput("b_b2b", {31'd0, ENG_RST}, 32'd0);
    streamFrom(31);
    engineDone(16'h6789);
    checkOutput("b_parked", {31'd0, ENG_RST}, 32'd1);
    checkOutput("b_head1", {16'd0, outCoords()}, 32'h2345);
    repeat (10) tick();
    checkOutput("b_still_parked", {31'd0, ENG_RST}, 32'd1);
    checkOutput("b_busy", {31'd0, BUSY}, 32'd0);
    popOne();
    checkOutput("b_rst_at_pop", {31'd0, ENG_RST}, 32'd1);
    checkOutput("b_head2", {16'd0, outCoords()}, 32'h6789);
    tick();
    checkOutput("b_launch_after_pop", {31'd0, ENG_RST}, 32'd0);
    streamFrom(32);
    engineDone(16'hABCD);
    checkOutput("b_park3", {31'd0, ENG_RST}, 32'd1);
    checkOutput("b_order1", {16'd0, outCoords()}, 32'h6789);
    popOne();
    checkOutput("b_order2", {16'd0, outCoords()}, 32'hABCD);
    popOne();
    checkOutput("b_drained", {31'd0, OUT_VALID}, 32'd0);

    // Reset in the middle of a stream with a result still queued.
    applyStimulus(40);
    tick();
    repeat (45) tick();
    engineDone(16'h1111);
    checkOutput("c_out_valid", {31'd0, OUT_VALID}, 32'd1);
    applyStimulus(41);
    tick();
    checkOutput("c_launch", {31'd0, ENG_RST}, 32'd0);
    repeat (17) tick();
    checkOutput("c_pt17", {24'd0, ENG_X, ENG_Y}, {24'd0, ptX(41, 17), ptY(41, 17)});
    #2 RST = 1'b0;
    #1;
    checkOutput("c_rst_eng_rst", {31'd0, ENG_RST}, 32'd1);
    checkOutput("c_rst_eng_xy", {24'd0, ENG_X, ENG_Y}, 32'd0);
    checkOutput("c_rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("c_rst_in_ready", {31'd0, IN_READY}, 32'd0);
    checkOutput("c_rst_out", {14'd0, OUT_VALID, outCoords(), OUT_TIMEOUT}, 32'd0);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    tick();
    checkOutput("c_ready", {31'd0, IN_READY}, 32'd1);
    runRec(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
